// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
package iter_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = DIV_WIDTH;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

  // One-hot encoding, matching the mul/div controller FSM style
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    BUSY  = 5'b00010,
    FIX   = 5'b00100,
    DONE  = 5'b01000,
    REARM = 5'b10000
  } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the EX mul/div controller and the divider.
interface iter_divider_if import iter_divider_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic               div;
  logic               sign;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               cancel;
  logic [2*WIDTH-1:0] result;
  logic               complete;

  modport master (
    output div, sign, x, y, cancel,
    input  result, complete
  );

  modport slave (
    input  div, sign, x, y, cancel,
    output result, complete
  );

endinterface

// File: rtl/iter_divider_div_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fixing.
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  always_comb begin
    val_o = neg_i ? (~val_i + 1'b1) : val_i;
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Build option DIV_EARLY_OUT_EN: skip iteration when |x| < |y| and y != 0.
module iter_divider import iter_divider_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  iter_divider_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS);

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   x_abs, y_abs, quo_fix, rem_fix, rem_sub;
  logic [WIDTH:0]     rem_sh;
  logic               ge;

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_x (
    .val_i(bus.x), .neg_i(bus.sign & bus.x[WIDTH-1]), .val_o(x_abs)
  );
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_y (
    .val_i(bus.y), .neg_i(bus.sign & bus.y[WIDTH-1]), .val_o(y_abs)
  );
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .val_i(quo_q), .neg_i(negq_q), .val_o(quo_fix)
  );
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .val_i(rem_q), .neg_i(negr_q), .val_o(rem_fix)
  );

  // Quotient register doubles as the dividend shift register
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, dsr_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - dsr_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (bus.div) begin
          rem_d   = '0;
          quo_d   = x_abs;
          dsr_d   = y_abs;
          cnt_d   = '0;
          negq_d  = bus.sign & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
          negr_d  = bus.sign & bus.x[WIDTH-1];
          dz_d    = (bus.y == '0);
          state_d = BUSY;
`ifdef DIV_EARLY_OUT_EN
          if ((y_abs != '0) && (x_abs < y_abs)) begin
            rem_d   = x_abs;
            quo_d   = '0;
            state_d = FIX;
          end
`endif
        end
      end
      BUSY: begin
        rem_d = ge ? rem_sub : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = {rem_fix, dz_q ? DIV0_QUOT : quo_fix};
        state_d  = DONE;
      end
      DONE: begin
        state_d = REARM;
      end
      REARM: begin
        if (!bus.div) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort keeps the previous result; a pulse already in DONE still goes out
    if (bus.cancel) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.complete = (state_q == DONE);

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (honours DIV_EARLY_OUT_EN).
module tb_iter_divider;
  import iter_divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   seen;
  logic [63:0] prev;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  iter_divider_if #(.WIDTH(32)) bus ();

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise div for a new request and return the cycle offset at which complete appears
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int l);
    l = -1;
    @(posedge clk); #1;
    bus.div = 1'b1; bus.sign = s; bus.x = a; bus.y = b;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.x = $urandom; bus.y = $urandom; bus.sign = ~s;
      end
      if (bus.complete === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic release_div();
    bus.div = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic count_completes(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (bus.complete === 1'b1) n++;
    end
  endtask

  initial begin
    bus.div = 1'b0; bus.sign = 1'b0; bus.x = '0; bus.y = '0; bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.result, 64'h0);
    check("reset_complete", {63'h0, bus.complete}, 64'h0);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, lat);
    check("udiv_lat", lat, 34);
    check("udiv_res", bus.result, {32'h00000002, 32'h0000000E});
    release_div();

    run_op(1'b1, 32'hFFFFFFF9, 32'd2, lat);
    check("sdiv_neg_lat", lat, 34);
    check("sdiv_neg_res", bus.result, {32'hFFFFFFFF, 32'hFFFFFFFD});
    release_div();

    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    check("sdiv_ovf_res", bus.result, {32'h00000000, 32'h80000000});
    release_div();

    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat);
    check("udiv_big_res", bus.result, {32'h80000000, 32'h00000000});
    release_div();

    run_op(1'b1, 32'h12345678, 32'h0, lat);
    check("div0_lat", lat, 34);
    check("div0_res", bus.result, {32'h12345678, 32'hFFFFFFFF});
    release_div();

    run_op(1'b1, 32'hFFFFFFF9, 32'h0, lat);
    check("div0_negx_res", bus.result, {32'hFFFFFFF9, 32'hFFFFFFFF});
    release_div();

    // Cancel at N+10
    prev = bus.result;
    @(posedge clk); #1;
    bus.div = 1'b1; bus.sign = 1'b0; bus.x = 32'd100; bus.y = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1; bus.div = 1'b0;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_state", {59'h0, dut.state_q}, {59'h0, IDLE});
    check("cancel_complete", {63'h0, bus.complete}, 64'h0);
    check("cancel_result", bus.result, prev);
    count_completes(40, seen);
    check("cancel_no_pulse", seen, 0);

    // div held high after completion must not restart
    run_op(1'b0, 32'd1000, 32'd10, lat);
    check("hold_first_res", bus.result, {32'd0, 32'd100});
    count_completes(40, seen);
    check("hold_no_restart", seen, 0);
    check("hold_state", {59'h0, dut.state_q}, {59'h0, REARM});
    release_div();

    // Reset during BUSY
    @(posedge clk); #1;
    bus.div = 1'b1; bus.sign = 1'b0; bus.x = 32'd100; bus.y = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; bus.div = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_result", bus.result, 64'h0);
    check("midrst_complete", {63'h0, bus.complete}, 64'h0);
    run_op(1'b0, 32'd9, 32'd3, lat);
    check("after_rst_lat", lat, 34);
    check("after_rst_res", bus.result, {32'd0, 32'd3});
    release_div();

    // Small dividend: early-out path when enabled
    run_op(1'b1, 32'd3, 32'd9, lat);
    check("small_lat", lat, EARLY_LAT);
    check("small_res", bus.result, {32'd3, 32'd0});
    release_div();

    run_op(1'b1, 32'hFFFFFFFD, 32'd9, lat);
    check("small_neg_lat", lat, EARLY_LAT);
    check("small_neg_res", bus.result, {32'hFFFFFFFD, 32'd0});
    release_div();

    run_op(1'b0, 32'd0, 32'd5, lat);
    check("zero_x_res", bus.result, 64'h0);
    release_div();

    // Cancel arriving in DONE keeps the pulse
    run_op(1'b0, 32'd50, 32'd6, lat);
    bus.cancel = 1'b1;
    #1;
    check("cancel_done_pulse", {63'h0, bus.complete}, 64'h1);
    check("cancel_done_res", bus.result, {32'd2, 32'd8});
    bus.div = 1'b0;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_done_state", {59'h0, dut.state_q}, {59'h0, IDLE});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Multi-cycle radix-2 restoring divider that computes the HI/LO results for DIV and DIVU in the EX multiply/divide unit.
- The EX mul/div controller asserts the start level, holds the EX stall while waiting, and latches the result into HI/LO on the completion pulse.
- Performs signed and unsigned 32-bit division with MIPS sign rules.
- Result layout is {remainder, quotient}, which maps to {HI, LO}.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits; DIV_ITERS = WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
div  in  1  start level; sampled only in IDLE; controller holds it until it sees complete
sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with div
x  in  WIDTH  dividend; sampled with div
y  in  WIDTH  divisor; sampled with div
cancel  in  1  abort the current operation (exception flush)
result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
complete  out  1  one-cycle pulse; result is valid in this cycle

Behaviour:
- Reset: state=IDLE, complete=0, result=0, counter=0. Reset mid-operation aborts with no complete.
- States: IDLE, BUSY, FIX, DONE, REARM.
- IDLE, div=1 (cycle N):
  - Latch |x| and |y| (absolute values when sign=1, raw when sign=0).
  - Latch neg_q = sign & (x[31]^y[31]) and neg_r = sign & x[31].
  - Clear counter; go to BUSY.
- BUSY: one restoring step per cycle.
  - Partial remainder is WIDTH+1 bits; compare and subtract the divisor, shift in one quotient bit.
  - After DIV_ITERS cycles (counter = WIDTH-1), go to FIX.
- FIX:
  - Negate quotient if neg_q; negate remainder if neg_r.
  - Register into result; go to DONE.
- DONE: complete=1 for exactly this cycle; go to REARM.
- REARM: wait until div=0, then go to IDLE. A div level still high from the last request never restarts a division.
- Latency: complete in cycle N+WIDTH+2 (N+34 at default).
- result holds its value from complete until the next FIX, or until reset.
- Divide by zero (y=0): quotient = all-ones, remainder = x, for both signed and unsigned. Full latency, no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Needs no special case; the magnitudes are treated as unsigned.
- cancel=1 in any state: go to IDLE next cycle, complete stays 0, result unchanged.
  - cancel wins over a simultaneous div in IDLE.
  - cancel in DONE does not suppress the pulse already being driven.
- x and y changing after the start sample have no effect.

Optional Feature:
Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if y!=0 and |x|<|y| (including x=0), skip BUSY and go straight to FIX with quotient 0 and remainder |x|. Sign fixing is applied as usual, so remainder = x. complete arrives in cycle N+2.
- Undefined: every operation takes the fixed N+WIDTH+2 latency.

Decomposition:
- Shared package holds:
  - state encoding constants, one-hot 5-bit to match the codebase's mul/div FSM style;
  - DIV_ITERS;
  - the divide-by-zero quotient constant.
- One sub-module is natural: div_sign_fix, purely combinational. It takes a value and a negate flag and returns the conditionally negated value. It is instantiated for the operand absolute values and for the FIX stage.

Test Plan:
- Unsigned: x=100, y=7, sign=0 -> complete at N+34, result={0x00000002, 0x0000000E}.
- Signed: x=0xFFFFFFF9 (-7), y=2, sign=1 -> result={0xFFFFFFFF, 0xFFFFFFFD} (r=-1, q=-3).
- Overflow and unsigned contrast: x=0x80000000, y=0xFFFFFFFF -> sign=1: {0x0, 0x80000000}; sign=0: {0x80000000, 0x0}.
- Divide by zero: x=0x12345678, y=0, sign=1 -> result={0x12345678, 0xFFFFFFFF}, complete at N+34.
- Cancel and rearm:
  - cancel at N+10 -> no complete, result unchanged, state=IDLE at N+11.
  - div held high through complete -> no second operation until div is seen low.
- Reset mid-BUSY (N+20): result=0, complete=0. A new x=9, y=3 then yields {0, 3} with full latency. With DIV_EARLY_OUT_EN, x=3, y=9 gives {3, 0} at N+2.
